// File: rtl/ssd_scan_driver.sv
// Digit-stream receiver: stages an 8-digit hex frame, commits it on shift_strobe and
// time-multiplexes the committed frame onto an 8-digit common-anode seven-segment panel.
module ssd_scan_driver #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          LZ_BLANK     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] display_char,
  input  logic [7:0] ssd_en,
  input  logic       shift_strobe,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       frame_valid,
  output logic       frame_drop
);
  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [31:0]   staging, staging_next, frame;
  logic          err, one_hot, multi_hot;
  logic [CW-1:0] slot_cnt, slot_cnt_next;
  logic [2:0]    scan_idx, scan_idx_next;
  logic [3:0]    digit;
  logic          digit_blank;
  logic [6:0]    seg_next;
  logic [7:0]    an_next;

  // Staging write; next-state view includes this cycle's nibble so a strobe commits it
  always_comb begin
    one_hot      = (ssd_en != '0) && ((ssd_en & (ssd_en - 8'd1)) == '0);
    multi_hot    = (ssd_en != '0) && !one_hot;
    staging_next = staging;
    for (int unsigned i = 0; i < 8; i++)
      if (one_hot && ssd_en[i]) staging_next[4*i +: 4] = display_char;
  end

  always_comb begin
    if (slot_cnt == CW'(REFRESH_DIV - 1)) begin
      slot_cnt_next = '0;
      scan_idx_next = scan_idx + 3'd1;
    end else begin
      slot_cnt_next = slot_cnt + CW'(1);
      scan_idx_next = scan_idx;
    end
  end

  // Outputs are computed from the next-state scan position so an/seg line up with slot_cnt
  always_comb begin
    digit       = frame[{scan_idx_next, 2'b00} +: 4];
    digit_blank = LZ_BLANK && (scan_idx_next != 3'd0) &&
                  ((frame >> {scan_idx_next, 2'b00}) == '0);
    case (digit)
      4'h0:    seg_next = 7'h40;
      4'h1:    seg_next = 7'h79;
      4'h2:    seg_next = 7'h24;
      4'h3:    seg_next = 7'h30;
      4'h4:    seg_next = 7'h19;
      4'h5:    seg_next = 7'h12;
      4'h6:    seg_next = 7'h02;
      4'h7:    seg_next = 7'h78;
      4'h8:    seg_next = 7'h00;
      4'h9:    seg_next = 7'h10;
      4'hA:    seg_next = 7'h08;
      4'hB:    seg_next = 7'h03;
      4'hC:    seg_next = 7'h46;
      4'hD:    seg_next = 7'h21;
      4'hE:    seg_next = 7'h06;
      default: seg_next = 7'h0E;
    endcase
    if (!frame_valid || digit_blank) seg_next = 7'h7F;
    an_next = (frame_valid && (slot_cnt_next >= CW'(BLANK_CYCLES)))
              ? ~(8'h01 << scan_idx_next) : 8'hFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staging     <= '0;
      frame       <= '0;
      err         <= 1'b0;
      slot_cnt    <= '0;
      scan_idx    <= '0;
      an          <= '1;
      seg         <= '1;
      frame_valid <= 1'b0;
      frame_drop  <= 1'b0;
    end else begin
      staging    <= staging_next;
      slot_cnt   <= slot_cnt_next;
      scan_idx   <= scan_idx_next;
      an         <= an_next;
      frame_drop <= 1'b0;
      // Segment pattern only reloads on the slot boundary, while anodes are blanked
      if (slot_cnt_next == '0) seg <= seg_next;
      if (shift_strobe) begin
        err <= 1'b0;
        if (err || multi_hot) begin
          frame_drop <= 1'b1;
        end else begin
          frame       <= staging_next;
          frame_valid <= 1'b1;
        end
      end else if (multi_hot) begin
        err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against two instances (LZ_BLANK 0 and 1).
module tb_ssd_scan_driver;
  localparam int RD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] display_char = '0;
  logic [7:0] ssd_en = '0;
  logic       shift_strobe = 1'b0;
  logic [7:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       fv0, fv1, fd0, fd1;

  ssd_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_BLANK(1'b0)) dut (
    .clk(clk), .rst(rst), .display_char(display_char), .ssd_en(ssd_en),
    .shift_strobe(shift_strobe), .an(an0), .seg(seg0), .frame_valid(fv0), .frame_drop(fd0));

  ssd_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_BLANK(1'b1)) dut_lz (
    .clk(clk), .rst(rst), .display_char(display_char), .ssd_en(ssd_en),
    .shift_strobe(shift_strobe), .an(an1), .seg(seg1), .frame_valid(fv1), .frame_drop(fd1));

  always #5 clk = ~clk;

  // Cycles since reset release; outputs seen after edge n belong to slot_cnt n%RD
  int ncyc = 0;
  always @(posedge clk or posedge rst)
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;

  typedef struct {
    int         cyc;
    int         inst;
    logic [3:0] mask;   // {an, seg, fv, fd}
    logic [7:0] an;
    logic [6:0] seg;
    logic       fv;
    logic       fd;
    string      name;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] seg_a  [8] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79}; // 12345678
  logic [6:0] seg_b0 [8] = '{7'h0E, 7'h40, 7'h40, 7'h08, 7'h40, 7'h40, 7'h40, 7'h40}; // 0000A00F
  logic [6:0] seg_b1 [8] = '{7'h0E, 7'h40, 7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  logic [6:0] seg_c0 [8] = '{7'h0E, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40, 7'h40, 7'h40}; // 000A000F
  logic [6:0] seg_c1 [8] = '{7'h0E, 7'h40, 7'h40, 7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F};
  logic [6:0] seg_d  [8] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}; // 87654321
  logic [6:0] seg_e  [8] = '{7'h0E, 7'h06, 7'h06, 7'h03, 7'h21, 7'h08, 7'h06, 7'h21}; // DEADBEEF

  function automatic void add(input int cyc, input int inst, input string name,
                              input logic [3:0] mask, input logic [7:0] a,
                              input logic [6:0] s, input logic v, input logic d);
    exp_t e;
    e.cyc = cyc; e.inst = inst; e.name = name; e.mask = mask;
    e.an = a; e.seg = s; e.fv = v; e.fd = d;
    sb.push_back(e);
  endfunction

  function automatic int slot_cyc(input int from, input int k, input int ph);
    int c;
    c = from;
    while (!(((c % RD) == ph) && (((c / RD) % 8) == k))) c++;
    return c;
  endfunction

  task automatic check(input exp_t e);
    logic [7:0] a;
    logic [6:0] s;
    logic       v, d;
    bit         bad;
    a = (e.inst != 0) ? an1  : an0;
    s = (e.inst != 0) ? seg1 : seg0;
    v = (e.inst != 0) ? fv1  : fv0;
    d = (e.inst != 0) ? fd1  : fd0;
    bad = (e.mask[3] && (a !== e.an)) || (e.mask[2] && (s !== e.seg)) ||
          (e.mask[1] && (v !== e.fv)) || (e.mask[0] && (d !== e.fd));
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s cyc=%0d inst=%0d: got an=%h seg=%h fv=%b fd=%b, want an=%h seg=%h fv=%b fd=%b (mask %b)",
               e.name, e.cyc, e.inst, a, s, v, d, e.an, e.seg, e.fv, e.fd, e.mask);
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc < ncyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s: check for cycle %0d never sampled (now %0d)", sb[i].name, sb[i].cyc, ncyc);
          sb.delete(i);
        end else if (sb[i].cyc == ncyc) begin
          check(sb[i]);
          sb.delete(i);
        end
      end
    end
  end

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks still pending after %0d cycles", sb.size(), limit);
      sb.delete();
    end
  endtask

  task automatic send_frame(input logic [31:0] data, input int bad_pos, output int s);
    s = 0;
    for (int i = 7; i >= 0; i--) begin
      @(posedge clk); #1;
      ssd_en       = (i == bad_pos) ? 8'h18 : (8'h01 << i);
      display_char = data[4*i +: 4];
      shift_strobe = (i == 0);
      s = ncyc;
    end
    @(posedge clk); #1;
    ssd_en       = '0;
    shift_strobe = 1'b0;
  endtask

  task automatic push_commit(input int s, input logic drop, input string tag);
    for (int inst = 0; inst < 2; inst++) begin
      add(s + 1, inst, {tag, " strobe+1"}, 4'b0011, 8'h00, 7'h00, 1'b1, drop);
      add(s + 2, inst, {tag, " strobe+2"}, 4'b0011, 8'h00, 7'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic push_frame(input int inst, input int b, input logic [6:0] segs [8], input string tag);
    int         phs [4];
    int         ph;
    logic [7:0] a;
    phs = '{0, 1, BC, RD - 1};
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < 4; p++) begin
        ph = phs[p];
        a  = (ph < BC) ? 8'hFF : ~(8'h01 << k);
        add(slot_cyc(b, k, ph), inst, $sformatf("%s k%0d ph%0d", tag, k, ph),
            4'b1110, a, segs[k], 1'b1, 1'b0);
      end
    end
  endtask

  function automatic int boundary_after(input int s);
    return ((s + 1) / RD + 1) * RD;
  endfunction

  int s;
  int b;
  int j;

  initial begin
    // 1: reset values, then 100 idle cycles
    repeat (3) @(posedge clk);
    #1;
    for (int inst = 0; inst < 2; inst++)
      add(0, inst, "reset", 4'b1111, 8'hFF, 7'h7F, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 1; c <= 100; c++)
      for (int inst = 0; inst < 2; inst++)
        add(c, inst, "idle", 4'b1111, 8'hFF, 7'h7F, 1'b0, 1'b0);
    drain(200);

    // 2: first frame
    send_frame(32'h12345678, -1, s);
    push_commit(s, 1'b0, "t2");
    b = boundary_after(s);
    push_frame(0, b, seg_a, "t2");
    push_frame(1, b, seg_a, "t2lz");
    drain(200);

    // 3: leading-zero blanking
    send_frame(32'h0000A00F, -1, s);
    push_commit(s, 1'b0, "t3a");
    b = boundary_after(s);
    push_frame(0, b, seg_b0, "t3a");
    push_frame(1, b, seg_b1, "t3alz");
    drain(200);

    send_frame(32'h000A000F, -1, s);
    push_commit(s, 1'b0, "t3b");
    b = boundary_after(s);
    push_frame(0, b, seg_c0, "t3b");
    push_frame(1, b, seg_c1, "t3blz");
    drain(200);

    // 4: multi-hot write drops the frame; previous frame stays
    send_frame(32'h11111111, 4, s);
    push_commit(s, 1'b1, "t4drop");
    b = boundary_after(s);
    push_frame(0, b, seg_c0, "t4keep");
    push_frame(1, b, seg_c1, "t4keeplz");
    drain(200);

    send_frame(32'h12345678, -1, s);
    push_commit(s, 1'b0, "t4clean");
    b = boundary_after(s);
    push_frame(0, b, seg_a, "t4clean");
    push_frame(1, b, seg_a, "t4cleanlz");
    drain(200);

    // 5: commit mid-slot, old digit holds until the boundary
    j = 0;
    while ((ncyc % RD) != 4 && j < 2 * RD) begin
      @(posedge clk); #1;
      j++;
    end
    send_frame(32'h87654321, -1, s);
    push_commit(s, 1'b0, "t5");
    b = boundary_after(s);
    for (int c = s + 1; c < b; c++) begin
      j = (c / RD) % 8;
      for (int inst = 0; inst < 2; inst++)
        add(c, inst, $sformatf("t5 hold c%0d", c % RD), 4'b1110,
            ((c % RD) < BC) ? 8'hFF : ~(8'h01 << j), seg_a[j], 1'b1, 1'b0);
    end
    push_frame(0, b, seg_d, "t5new");
    push_frame(1, b, seg_d, "t5newlz");
    drain(200);

    // 6: reset mid-frame, then a fresh frame
    for (int i = 7; i >= 4; i--) begin
      @(posedge clk); #1;
      ssd_en       = 8'h01 << i;
      display_char = 4'h5;
    end
    @(posedge clk); #1;
    ssd_en = '0;
    rst    = 1'b1;
    for (int inst = 0; inst < 2; inst++)
      add(0, inst, "t6 reset", 4'b1111, 8'hFF, 7'h7F, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 1; c <= 20; c++)
      for (int inst = 0; inst < 2; inst++)
        add(c, inst, "t6 idle", 4'b1111, 8'hFF, 7'h7F, 1'b0, 1'b0);
    drain(200);

    send_frame(32'hDEADBEEF, -1, s);
    push_commit(s, 1'b0, "t6");
    b = boundary_after(s);
    push_frame(0, b, seg_e, "t6");
    push_frame(1, b, seg_e, "t6lz");
    drain(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
